// File: rtl/mac_pipe_param_if.sv
// Operand and result handshake bundle for the pipelined MAC.
// slave is the MAC side, master is the operand source / result sink.
interface mac_pipe_param_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2*WIDTH+8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_clear;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_clear, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_clear, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/mac_pipe_param.sv
// Four-stage unsigned multiply-accumulate: split-operand partial products,
// recombine, accumulate; a last beat emits the sum on a valid/ready port.
module mac_pipe_param #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 2*WIDTH+8,
  parameter bit SATURATE  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  mac_pipe_param_if.slave bus
);
  localparam int H   = WIDTH/2;
  localparam int PW  = 2*WIDTH;
  localparam int AW1 = ACC_WIDTH+1;

  logic en, accept;
  logic v1, v2, v3;
  logic c1, c2, c3;
  logic l1, l2, l3;
  logic [WIDTH-1:0] a1, b1;
  logic [WIDTH-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [PW-1:0] p_c, p3;
  logic [ACC_WIDTH-1:0] acc, base, res, out_acc;
  logic [AW1-1:0] sum;
  logic sticky, ovf_now, stk;
  logic out_valid, out_ovf;

  // Whole pipe freezes only while a result sits unaccepted.
  assign en     = !(out_valid && !bus.out_ready);
  assign accept = bus.in_valid && en;

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid;
  assign bus.out_acc   = out_acc;
  assign bus.out_ovf   = out_ovf;

  assign p_c = PW'(pp_ll)
             + (PW'(pp_hl) << H)
             + (PW'(pp_lh) << H)
             + (PW'(pp_hh) << WIDTH);

  always_comb begin
    base    = c3 ? '0 : acc;
    sum     = {1'b0, base} + AW1'(p3);
    ovf_now = sum[ACC_WIDTH];
    res     = (SATURATE && ovf_now) ? '1 : sum[ACC_WIDTH-1:0];
    stk     = (c3 ? 1'b0 : sticky) | ovf_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      c1 <= 1'b0;
      l1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else if (en) begin
      v1 <= accept;
      if (accept) begin
        a1 <= bus.in_a;
        b1 <= bus.in_b;
        c1 <= bus.in_clear;
        l1 <= bus.in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      c2    <= 1'b0;
      l2    <= 1'b0;
      pp_ll <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
      pp_hh <= '0;
    end else if (en) begin
      v2    <= v1;
      c2    <= c1;
      l2    <= l1;
      pp_ll <= WIDTH'(a1[H-1:0])     * WIDTH'(b1[H-1:0]);
      pp_hl <= WIDTH'(a1[WIDTH-1:H]) * WIDTH'(b1[H-1:0]);
      pp_lh <= WIDTH'(a1[H-1:0])     * WIDTH'(b1[WIDTH-1:H]);
      pp_hh <= WIDTH'(a1[WIDTH-1:H]) * WIDTH'(b1[WIDTH-1:H]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      c3 <= 1'b0;
      l3 <= 1'b0;
      p3 <= '0;
    end else if (en) begin
      v3 <= v2;
      c3 <= c2;
      l3 <= l2;
      p3 <= p_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      sticky  <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
    end else if (en && v3) begin
      if (l3) begin
        out_acc <= res;
        out_ovf <= stk;
        acc     <= '0;
        sticky  <= 1'b0;
      end else begin
        acc     <= res;
        sticky  <= stk;
      end
    end
  end

  // A fresh emit wins over consumption of the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (en && v3 && l3) begin
      out_valid <= 1'b1;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
